// File: rtl/decode_regfile_if.sv
// Fetch-to-decode bundle: register specifiers in, write-back results in,
// decoded IDs and operand values out.
interface decode_regfile_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              wb_en;
    logic [3:0]        wb_dstE;
    logic [DATA_W-1:0] wb_valE;
    logic [3:0]        wb_dstM;
    logic [DATA_W-1:0] wb_valM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;

    modport master (
        output icode, rA, rB, wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
        input  srcA, srcB, dstE, dstM, valA, valB
    );

    modport slave (
        input  icode, rA, rB, wb_en, wb_dstE, wb_valE, wb_dstM, wb_valM,
        output srcA, srcB, dstE, dstM, valA, valB
    );
endinterface

// File: rtl/decode_regfile.sv
// Y86-64 SEQ decode/write-back: combinational register-ID decode, asynchronous
// operand reads and clocked write-back into a 15-entry register file.
module decode_regfile #(
    parameter int                 DATA_W   = 64,
    parameter logic [DATA_W-1:0]  RSP_INIT = 64'd2048,
    parameter logic [3:0]         RNONE    = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    decode_regfile_if.slave   bus
);
    localparam logic [3:0] RSP_ID = 4'd4;
    localparam int         NREGS  = 15;

    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] regs_reg  [0:NREGS-1];
    logic [DATA_W-1:0] regs_next [0:NREGS-1];

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            4'h2: begin src_a = bus.rA; dst_e = bus.rB; end
            4'h3: begin dst_e = bus.rB; end
            4'h4: begin src_a = bus.rA; src_b = bus.rB; end
            4'h5: begin src_b = bus.rB; dst_m = bus.rA; end
            4'h6: begin src_a = bus.rA; src_b = bus.rB; dst_e = bus.rB; end
            4'h8: begin src_b = RSP_ID; dst_e = RSP_ID; end
            4'h9: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
            4'hA: begin src_a = bus.rA; src_b = RSP_ID; dst_e = RSP_ID; end
            4'hB: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = bus.rA; end
            default: ;
        endcase
    end

    assign bus.srcA = src_a;
    assign bus.srcB = src_b;
    assign bus.dstE = dst_e;
    assign bus.dstM = dst_m;

    // Reads see only committed state; RNONE has no backing entry and reads zero.
    assign bus.valA = (src_a == RNONE) ? '0 : regs_reg[src_a];
    assign bus.valB = (src_b == RNONE) ? '0 : regs_reg[src_b];

    // valM is tested first so it wins when both ports target the same register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : gen_reg
            localparam logic [DATA_W-1:0] INIT_VAL = (gi == 4) ? RSP_INIT : '0;
            assign regs_next[gi] = reset ? INIT_VAL :
                (bus.wb_en && bus.wb_dstM == 4'(gi)) ? bus.wb_valM :
                (bus.wb_en && bus.wb_dstE == 4'(gi)) ? bus.wb_valE :
                regs_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= regs_next[i];
        end
    end
endmodule

// File: tb/tb_decode_regfile.sv
// Directed plus randomized checks of decode_regfile against an array-based
// model of the architectural register file.
module tb_decode_regfile;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   steps;
    bit   model_valid;
    logic [63:0] model [0:14];

    decode_regfile_if #(.DATA_W(64)) bus ();

    decode_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_src_a(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_src_b(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_e(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h2, 4'h3, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_m(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] model_read(input logic [3:0] id);
        if (id == 4'hF) return 64'd0;
        return model[id];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] sa;
        logic [3:0] sb;
        sa = exp_src_a(bus.icode, bus.rA);
        sb = exp_src_b(bus.icode, bus.rB);
        chk("srcA", 64'(bus.srcA), 64'(sa));
        chk("srcB", 64'(bus.srcB), 64'(sb));
        chk("dstE", 64'(bus.dstE), 64'(exp_dst_e(bus.icode, bus.rB)));
        chk("dstM", 64'(bus.dstM), 64'(exp_dst_m(bus.icode, bus.rA)));
        chk("valA", bus.valA, model_read(sa));
        chk("valB", bus.valB, model_read(sb));
    endtask

    // One clocked transaction: outputs are checked before the edge, then the
    // model commits what the edge should have done.
    task automatic step(input logic rst, input logic [3:0] ic, input logic [3:0] a,
                        input logic [3:0] b, input logic en, input logic [3:0] de,
                        input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        reset       = rst;
        bus.icode   = ic;
        bus.rA      = a;
        bus.rB      = b;
        bus.wb_en   = en;
        bus.wb_dstE = de;
        bus.wb_valE = ve;
        bus.wb_dstM = dm;
        bus.wb_valM = vm;
        #1;
        if (model_valid) check_outputs();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 15; i++) model[i] = 64'd0;
            model[4] = 64'd2048;
            model_valid = 1'b1;
        end else if (en) begin
            if (de != 4'hF) model[de] = ve;
            if (dm != 4'hF) model[dm] = vm;
        end
        steps++;
        $display("step %0d rst=%0b icode=%h rA=%h rB=%h en=%0b dstE=%h valE=%0h dstM=%h valM=%0h",
                 steps, rst, ic, a, b, en, de, ve, dm, vm);
        #1;
    endtask

    task automatic peek(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
        reset     = 1'b0;
        bus.wb_en = 1'b0;
        bus.icode = ic;
        bus.rA    = a;
        bus.rB    = b;
        #1;
        check_outputs();
        $display("peek icode=%h rA=%h rB=%h -> valA=%0h valB=%0h", ic, a, b, bus.valA, bus.valB);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        steps       = 0;
        model_valid = 1'b0;

        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 64'd0, 4'hF, 64'd0);

        peek(4'h9, 4'h0, 4'h0);
        chk("reset_srcA", 64'(bus.srcA), 64'd4);
        chk("reset_srcB", 64'(bus.srcB), 64'd4);
        chk("reset_valA", bus.valA, 64'd2048);
        chk("reset_valB", bus.valB, 64'd2048);
        chk("reset_dstE", 64'(bus.dstE), 64'd4);
        chk("reset_dstM", 64'(bus.dstM), 64'hF);

        // Write r3 while reading it: the read must still return the old value.
        reset = 1'b0; bus.icode = 4'h6; bus.rA = 4'h3; bus.rB = 4'h3;
        bus.wb_en = 1'b1; bus.wb_dstE = 4'h3; bus.wb_valE = 64'h10; bus.wb_dstM = 4'hF;
        #1;
        chk("no_bypass_valA", bus.valA, 64'd0);
        step(1'b0, 4'h6, 4'h3, 4'h3, 1'b1, 4'h3, 64'h10, 4'hF, 64'd0);
        peek(4'h6, 4'h3, 4'h3);
        chk("irmov_valA", bus.valA, 64'd16);
        chk("irmov_valB", bus.valB, 64'd16);
        chk("irmov_dstE", 64'(bus.dstE), 64'd3);
        chk("irmov_dstM", 64'(bus.dstM), 64'hF);

        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 64'd2040, 4'h0, 64'd7);
        peek(4'h6, 4'h4, 4'h0);
        chk("dual_r4", bus.valA, 64'd2040);
        chk("dual_r0", bus.valB, 64'd7);

        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h4, 64'd2056, 4'h4, 64'd99);
        peek(4'h6, 4'h4, 4'h4);
        chk("conflict_r4", bus.valA, 64'd99);

        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 64'd5, 4'hF, 64'd0);
        peek(4'h6, 4'h2, 4'h2);
        chk("disabled_r2", bus.valA, 64'd0);

        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'hF, 64'd123, 4'hF, 64'd456);
        peek(4'h4, 4'hF, 4'h2);
        chk("rnone_valA", bus.valA, 64'd0);
        chk("rnone_srcA", 64'(bus.srcA), 64'hF);
        chk("rnone_r2", bus.valB, 64'd0);

        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h1, 64'd55, 4'hF, 64'd0);
        peek(4'h6, 4'h1, 4'h1);
        chk("held_r1", bus.valA, 64'd55);
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h1, 64'd77, 4'hF, 64'd0);
        peek(4'h6, 4'h1, 4'h4);
        chk("rst_prio_r1", bus.valA, 64'd0);
        chk("rst_prio_r4", bus.valB, 64'd2048);

        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 39) == 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 4'($urandom_range(0, 15)), {$urandom, $urandom});
        end

        for (int r = 0; r < 15; r++) begin
            peek(4'h6, 4'(r), 4'(14 - r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Y86-64 SEQ decode/write-back stage. Sits directly downstream of fetch.
- Consumes fetch's icode, rA and rB.
- Derives srcA, srcB, dstE and dstM, reads valA and valB from a 15-entry x 64-bit register file, and commits write-back results (valE, valM) on the clock edge.
- Provides the operands consumed by execute and memory.

Parameters:
- DATA_W, 64, register width in bits.
- RSP_INIT, 64'd2048, reset value of %rsp (register 4). Equals the top of the 2048-byte instruction memory.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous reset, active-high.
- icode  input  4  instruction code from fetch.
- rA  input  4  register specifier A from fetch.
- rB  input  4  register specifier B from fetch.
- wb_en  input  1  write-back enable for the current cycle.
- wb_dstE  input  4  destination of valE (RNONE = no write).
- wb_valE  input  64  ALU result to write.
- wb_dstM  input  4  destination of valM (RNONE = no write).
- wb_valM  input  64  memory result to write.
- srcA  output  4  decoded source A ID.
- srcB  output  4  decoded source B ID.
- dstE  output  4  decoded E destination ID.
- dstM  output  4  decoded M destination ID.
- valA  output  64  contents of register srcA.
- valB  output  64  contents of register srcB.

Behaviour:
- State: regs[0..14], DATA_W bits each. No physical register 15.

Decode (combinational from icode/rA/rB; 0 cycles latency):
- srcA = rA for icode 2,4,6,A; 4 (%rsp) for 9,B; else RNONE.
- srcB = rB for 4,5,6; 4 for 8,9,A,B; else RNONE.
- dstE = rB for 2,3,6; 4 for 8,9,A,B; else RNONE.
  - Cmov condition is applied downstream, not here.
- dstM = rA for 5,B; else RNONE.
- icode 0,1,7 and invalid codes C-F: all four IDs = RNONE.

Read (combinational, asynchronous):
- valA = regs[srcA]; valB = regs[srcB].
- ID RNONE reads 0.
- No write-through bypass: a write committed on edge N is visible to reads only after edge N.

Write (rising clk, when wb_en=1 and reset=0):
- wb_dstE != RNONE: regs[wb_dstE] <= wb_valE.
- wb_dstM != RNONE: regs[wb_dstM] <= wb_valM.
- Both in the same cycle to distinct registers: both commit.
- wb_dstE == wb_dstM (e.g. popq %rsp): valM wins.
- wb_en=0: no register changes, regardless of IDs.

Reset (synchronous):
- When reset=1 at a rising edge: all regs <= 0, except regs[4] <= RSP_INIT.
- Reset overrides any simultaneous write, including a write arriving mid-instruction.
- Outputs after reset: valA/valB reflect the reset contents (0, or RSP_INIT when the ID is 4). ID outputs track inputs.
- Before the first reset, register contents are undefined. The bench must assert reset for at least 1 cycle.

Width rules:
- Values are stored and returned exactly; no sign or zero manipulation.
- IDs above 14 other than RNONE cannot occur; 4'hF is the only unused ID.

Test Plan:
- Reset: reset=1 for 1 edge; then icode=9 (ret) -> srcA=4, srcB=4, valA=valB=2048, dstE=4, dstM=F.
- Irmovq write then read: wb_en=1, wb_dstE=3, wb_valE=64'h10, wb_dstM=F, 1 edge; then icode=6, rA=3, rB=3.
  - Required: valA=valB=16, dstE=3, dstM=F.
  - Same cycle as the write (before the edge): valA=0, confirming no bypass.
- Dual write: wb_dstE=4 / valE=2040 and wb_dstM=0 / valM=7 in one cycle -> next cycle regs[4]=2040 and regs[0]=7.
- Conflict: wb_dstE=4 / valE=2056 and wb_dstM=4 / valM=99 -> regs[4]=99.
- Disable and RNONE:
  - wb_en=0 with wb_dstE=2, valE=5 -> regs[2] unchanged (0).
  - wb_en=1, wb_dstE=F -> no register changes.
  - icode=4, rA=F, rB=2 -> valA=0.
- Reset priority: regs[1]=55 held; in one cycle apply reset=1 together with wb_en=1, wb_dstE=1, valE=77 -> regs[1]=0 and regs[4]=2048 afterwards.
